i2c_master: RTL and testbench

//  Single-master I2C register-access controller: START, 7-bit device address, 8-bit register

---
 rtl/i2c_master.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Single-master I2C register-access controller (START, dev addr, reg addr, 1-2 data bytes, STOP).
// Define I2C_STATE_DBG_EN to expose the FSM state code on state_o; otherwise it reads zero.
module i2c_master #(
  parameter int unsigned QTR = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        rw,
  input  logic [6:0]  addr,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] data,
  input  logic        burst,
  output logic        busy,
  output logic        err,
  output logic [15:0] data_o,
  inout  wire         sda,
  output logic        scl,
  output logic [5:0]  state_o
);

  localparam int unsigned CntW = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [5:0] {
    StIdle    = 6'd0,
    StStart   = 6'd1,
    StTxDevW  = 6'd2,
    StRxAck   = 6'd4,
    StTxMack  = 6'd8,
    StTxReg   = 6'd16,
    StRestart = 6'd17,
    StTxDevR  = 6'd18,
    StRdLow   = 6'd19,
    StTxData  = 6'd20,
    StStop    = 6'd32,
    StRdHigh  = 6'd33
  } state_e;

  state_e         state_q, state_d, ret_q, ret_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]     ph_q, ph_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d, hi_q, hi_d, reg_q, reg_d;
  logic [6:0]     addr_q, addr_d;
  logic [15:0]    dat_q, dat_d, data_q, data_d;
  logic           more_q, more_d, ack_q, ack_d, scl_q, scl_d, oe_q, oe_d;
  logic           err_q, err_d, rw_q, rw_d, burst_q, burst_d;
  logic           tick;

  assign tick   = (cnt_q == CntW'(QTR - 1));
  assign sda    = oe_q ? 1'b0 : 1'bz;
  assign scl    = scl_q;
  assign busy   = (state_q != StIdle);
  assign err    = err_q;
  assign data_o = data_q;

`ifdef I2C_STATE_DBG_EN
  assign state_o = state_q;
`else
  assign state_o = 6'd0;
`endif

  // Every bit spans four quarters: ph0/ph1 SCL low, ph2/ph3 SCL high.
  // Actions fire on the tick that ends the named quarter.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = '0;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    hi_d    = hi_q;
    more_d  = more_q;
    ack_d   = ack_q;
    scl_d   = scl_q;
    oe_d    = oe_q;
    err_d   = err_q;
    data_d  = data_q;
    rw_d    = rw_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    dat_d   = dat_q;

    if (state_q != StIdle) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) ph_d = ph_q + 2'd1;
    end

    case (state_q)
      StIdle: begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        ph_d  = 2'd0;
        bit_d = 3'd0;
        if (en) begin
          state_d = StStart;
          rw_d    = rw;
          burst_d = burst;
          addr_d  = addr;
          reg_d   = reg_addr;
          dat_d   = data;
          err_d   = 1'b0;
        end
      end

      StStart: if (tick) begin
        case (ph_q)
          2'd0: oe_d = 1'b1;
          2'd2: scl_d = 1'b0;
          2'd3: begin
            state_d = StTxDevW;
            sh_d    = {addr_q, 1'b0};
            bit_d   = 3'd0;
          end
          default: ;
        endcase
      end

      StTxDevW, StTxReg, StTxDevR, StTxData: if (tick) begin
        case (ph_q)
          2'd0: oe_d = ~sh_q[7];
          2'd1: scl_d = 1'b1;
          2'd3: begin
            scl_d = 1'b0;
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = StRxAck;
              ret_d   = state_q;
            end
          end
          default: ;
        endcase
      end

      StRxAck: if (tick) begin
        case (ph_q)
          2'd0: oe_d = 1'b0;
          2'd1: scl_d = 1'b1;
          2'd2: ack_d = sda;
          2'd3: begin
            scl_d = 1'b0;
            bit_d = 3'd0;
            if (ack_q) begin
              err_d   = 1'b1;
              state_d = StStop;
            end else begin
              case (ret_q)
                StTxDevW: begin
                  state_d = StTxReg;
                  sh_d    = reg_q;
                end
                StTxReg: begin
                  if (rw_q) begin
                    state_d = StRestart;
                  end else begin
                    state_d = StTxData;
                    sh_d    = burst_q ? dat_q[15:8] : dat_q[7:0];
                    more_d  = burst_q;
                  end
                end
                StTxDevR: begin
                  state_d = StRdLow;
                  more_d  = burst_q;
                end
                StTxData: begin
                  if (more_q) begin
                    state_d = StTxData;
                    sh_d    = dat_q[7:0];
                    more_d  = 1'b0;
                  end else begin
                    state_d = StStop;
                  end
                end
                default: state_d = StStop;
              endcase
            end
          end
          default: ;
        endcase
      end

      StRestart: if (tick) begin
        case (ph_q)
          2'd0: oe_d = 1'b0;
          2'd1: scl_d = 1'b1;
          2'd2: oe_d = 1'b1;
          2'd3: begin
            scl_d   = 1'b0;
            state_d = StTxDevR;
            sh_d    = {addr_q, 1'b1};
            bit_d   = 3'd0;
          end
          default: ;
        endcase
      end

      StRdLow: if (tick) begin
        if (ph_q == 2'd0) oe_d = 1'b0;
        if (ph_q == 2'd1) begin
          scl_d   = 1'b1;
          state_d = StRdHigh;
        end
      end

      StRdHigh: if (tick) begin
        if (ph_q == 2'd2) sh_d = {sh_q[6:0], sda};
        if (ph_q == 2'd3) begin
          scl_d   = 1'b0;
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? StTxMack : StRdLow;
        end
      end

      // Master ACKs only when another byte is still to be read.
      StTxMack: if (tick) begin
        case (ph_q)
          2'd0: oe_d = more_q;
          2'd1: scl_d = 1'b1;
          2'd3: begin
            scl_d = 1'b0;
            bit_d = 3'd0;
            if (more_q) begin
              hi_d    = sh_q;
              more_d  = 1'b0;
              state_d = StRdLow;
            end else begin
              data_d  = burst_q ? {hi_q, sh_q} : {8'h00, sh_q};
              state_d = StStop;
            end
          end
          default: ;
        endcase
      end

      StStop: if (tick) begin
        case (ph_q)
          2'd0: oe_d = 1'b1;
          2'd1: scl_d = 1'b1;
          2'd2: oe_d = 1'b0;
          2'd3: state_d = StIdle;
          default: ;
        endcase
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
      cnt_q   <= '0;
      ph_q    <= 2'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      hi_q    <= 8'h00;
      more_q  <= 1'b0;
      ack_q   <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 16'h0000;
      rw_q    <= 1'b0;
      burst_q <= 1'b0;
      addr_q  <= 7'h00;
      reg_q   <= 8'h00;
      dat_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      hi_q    <= hi_d;
      more_q  <= more_d;
      ack_q   <= ack_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: a task-driven I2C slave follows the bus bit by bit.
`timescale 1ns/1ps
module tb_i2c_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rw = 1'b0;
  logic        burst = 1'b0;
  logic [6:0]  addr = 7'h55;
  logic [7:0]  reg_addr = 8'hCC;
  logic [15:0] data = 16'h0000;
  logic        busy, err, scl;
  logic [15:0] data_o;
  logic [5:0]  state_o;
  logic        slave_oe = 1'b0;
  wire         sda;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  b;
  logic        m;

  assign sda = slave_oe ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master #(.QTR(25)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rw       (rw),
    .addr     (addr),
    .reg_addr (reg_addr),
    .data     (data),
    .burst    (burst),
    .busy     (busy),
    .err      (err),
    .data_o   (data_o),
    .sda      (sda),
    .scl      (scl),
    .state_o  (state_o)
  );

  // Expected debug state code; reads zero when the debug port is compiled out.
  function automatic logic [15:0] st(input logic [5:0] c);
`ifdef I2C_STATE_DBG_EN
    return {10'd0, c};
`else
    return {10'd0, c} & 16'h0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    bad++;
    total++;
    $display("FAIL %s: timed out waiting for bus", tag);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bus wait expired");
  endtask

  task automatic wait_scl(input logic lvl);
    int n = 0;
    while (scl !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (scl !== lvl) timeout("scl_wait");
  endtask

  task automatic wait_sda(input logic lvl);
    int n = 0;
    while (sda !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sda !== lvl) timeout("sda_wait");
  endtask

  task automatic launch(input logic r, input logic bst, input logic [15:0] d);
    rw = r;
    burst = bst;
    data = d;
    en = 1'b1;
    @(negedge clk);
    chk("busy_rise", {15'd0, busy}, 16'd1);
    chk("state_start", {10'd0, state_o}, st(6'd1));
    en = 1'b0;
  endtask

  task automatic bus_start(input string tag);
    wait_sda(1'b0);
    chk(tag, {15'd0, scl}, 16'd1);
    wait_scl(1'b0);
  endtask

  task automatic rd_byte(output logic [7:0] v);
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_scl(1'b1);
      v = {v[6:0], sda};
      wait_scl(1'b0);
    end
  endtask

  // a=0 acknowledges, a=1 leaves the line released (NACK).
  task automatic give_ack(input logic a);
    slave_oe = ~a;
    wait_scl(1'b1);
    wait_scl(1'b0);
    slave_oe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      slave_oe = ~v[i];
      wait_scl(1'b1);
      wait_scl(1'b0);
    end
    slave_oe = 1'b0;
  endtask

  task automatic get_mack(output logic v);
    wait_scl(1'b1);
    v = sda;
    chk("state_mack", {10'd0, state_o}, st(6'd8));
    wait_scl(1'b0);
  endtask

  task automatic bus_stop();
    int n = 0;
    wait_scl(1'b1);
    chk("stop_sda_low", {15'd0, sda}, 16'd0);
    wait_sda(1'b1);
    chk("stop_scl_high", {15'd0, scl}, 16'd1);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", {15'd0, busy}, 16'd0);
    chk("state_idle", {10'd0, state_o}, st(6'd0));
  endtask

  task automatic write_hdr();
    bus_start("start_scl");
    rd_byte(b);
    chk("devaddr_w", {8'd0, b}, 16'h00AA);
    give_ack(1'b0);
    rd_byte(b);
    chk("regaddr", {8'd0, b}, 16'h00CC);
    give_ack(1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_data", data_o, 16'h0000);
    chk("rst_scl", {15'd0, scl}, 16'd1);
    chk("rst_sda", {15'd0, sda}, 16'd1);
    chk("rst_state", {10'd0, state_o}, st(6'd0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1-byte read of 0x99
    launch(1'b1, 1'b0, 16'h0000);
    write_hdr();
    wait_scl(1'b1);
    wait_sda(1'b0);
    chk("restart_scl", {15'd0, scl}, 16'd1);
    wait_scl(1'b0);
    rd_byte(b);
    chk("devaddr_r", {8'd0, b}, 16'h00AB);
    give_ack(1'b0);
    send_byte(8'h99);
    get_mack(m);
    chk("mnack_last", {15'd0, m}, 16'd1);
    bus_stop();
    chk("rd1_data", data_o, 16'h0099);
    chk("rd1_err", {15'd0, err}, 16'd0);

    // 1-byte write
    launch(1'b0, 1'b0, 16'h3366);
    write_hdr();
    rd_byte(b);
    chk("wr1_byte", {8'd0, b}, 16'h0066);
    give_ack(1'b0);
    bus_stop();
    chk("wr1_err", {15'd0, err}, 16'd0);
    chk("wr1_data_keep", data_o, 16'h0099);

    // 2-byte write; inputs scrambled after launch must be ignored
    launch(1'b0, 1'b1, 16'h3366);
    data = 16'hFFFF;
    burst = 1'b0;
    addr = 7'h00;
    write_hdr();
    rd_byte(b);
    chk("wr2_byte1", {8'd0, b}, 16'h0033);
    give_ack(1'b0);
    rd_byte(b);
    chk("wr2_byte2", {8'd0, b}, 16'h0066);
    give_ack(1'b0);
    bus_stop();
    chk("wr2_data_keep", data_o, 16'h0099);
    addr = 7'h55;

    // 2-byte read of 0x12, 0x34
    launch(1'b1, 1'b1, 16'h0000);
    write_hdr();
    wait_scl(1'b1);
    wait_sda(1'b0);
    wait_scl(1'b0);
    rd_byte(b);
    chk("rd2_devaddr", {8'd0, b}, 16'h00AB);
    give_ack(1'b0);
    send_byte(8'h12);
    get_mack(m);
    chk("mack_first", {15'd0, m}, 16'd0);
    send_byte(8'h34);
    get_mack(m);
    chk("mnack_second", {15'd0, m}, 16'd1);
    bus_stop();
    chk("rd2_data", data_o, 16'h1234);

    // NACK on device address
    launch(1'b0, 1'b0, 16'h00A5);
    bus_start("nack_start");
    rd_byte(b);
    chk("nack_devaddr", {8'd0, b}, 16'h00AA);
    wait_scl(1'b1);
    chk("state_rxack", {10'd0, state_o}, st(6'd4));
    wait_scl(1'b0);
    @(negedge clk);
    chk("state_stop", {10'd0, state_o}, st(6'd32));
    bus_stop();
    chk("nack_err", {15'd0, err}, 16'd1);
    chk("nack_data_keep", data_o, 16'h1234);

    // next transaction clears err
    launch(1'b0, 1'b0, 16'h0011);
    chk("err_cleared", {15'd0, err}, 16'd0);
    write_hdr();
    rd_byte(b);
    chk("wr3_byte", {8'd0, b}, 16'h0011);
    give_ack(1'b0);
    bus_stop();

    // asynchronous reset during the register-address byte
    launch(1'b0, 1'b0, 16'h0022);
    bus_start("rst_start");
    rd_byte(b);
    give_ack(1'b0);
    wait_scl(1'b1);
    wait_scl(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", {15'd0, scl}, 16'd1);
    chk("mid_rst_sda", {15'd0, sda}, 16'd1);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_state", {10'd0, state_o}, st(6'd0));
    chk("mid_rst_data", data_o, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {15'd0, busy}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
